// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO control register block:
// register addresses, ISTAT bit positions, FSM state type and the LOCK key.
package gpio_ctrl_pkg;

    localparam logic [3:0] ADDR_DATA  = 4'd0;
    localparam logic [3:0] ADDR_DIR   = 4'd1;
    localparam logic [3:0] ADDR_PIN   = 4'd2;
    localparam logic [3:0] ADDR_IMASK = 4'd3;
    localparam logic [3:0] ADDR_PCMSK = 4'd4;
    localparam logic [3:0] ADDR_EDGE  = 4'd5;
    localparam logic [3:0] ADDR_FUNC  = 4'd6;
    localparam logic [3:0] ADDR_ISTAT = 4'd7;
    localparam logic [3:0] ADDR_IEN   = 4'd8;
    localparam logic [3:0] ADDR_LOCK  = 4'd9;

    localparam int ISTAT_INT0      = 0;
    localparam int ISTAT_INT1      = 1;
    localparam int ISTAT_PINCHANGE = 2;

    localparam logic [7:0] LOCK_KEY = 8'hA5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/gpio_irq_capture.sv
// Rising-edge detection on the three interrupt levels with sticky,
// write-one-to-clear status; a new edge wins over a simultaneous clear.
module gpio_irq_capture
    import gpio_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_int0,
    input  logic       irq_int1,
    input  logic       irq_pinchange,
    input  logic [2:0] clr,
    output logic [2:0] status
);

    logic [2:0] level;
    logic [2:0] prev;

    always_comb begin
        level                  = '0;
        level[ISTAT_INT0]      = irq_int0;
        level[ISTAT_INT1]      = irq_int1;
        level[ISTAT_PINCHANGE] = irq_pinchange;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= '0;
            status <= '0;
        end else begin
            prev   <= level;
            status <= (status & ~clr) | (level & ~prev);
        end
    end

endmodule

// File: rtl/gpio_ctrl_regs.sv
// GPIO control register file with a valid/ready request/response port.
// Optional write lock on DIR/FUNC is built when GPIO_CTRL_REGS_LOCK_EN is defined.
//
// state   | meaning
// IDLE    | no response pending, ready for a request
// RESP    | response presented, waiting for rsp_ready
module gpio_ctrl_regs
    import gpio_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] data_in,
    output logic [15:0] dir_in,
    output logic        write_data_enable,
    output logic        write_dir_enable,
    output logic [31:0] interrupt_mask,
    output logic [15:0] pinchange_msk,
    output logic [1:0]  int0_msk,
    output logic [1:0]  int1_msk,
    output logic        EN_PWM_OUTA0,
    output logic        EN_PWM_OUTB0,
    output logic        EN_TMR_IN0,
    output logic        EN_I2C,
    output logic        EN_SPI,
    output logic        EN_UART,
    input  logic [15:0] gpio_data_in,
    input  logic        irq_int0,
    input  logic        irq_int1,
    input  logic        irq_pinchange,
    output logic        irq
);

    state_t      state, state_nxt;
    logic        accept;
    logic        wr_blocked;
    logic [3:0]  edge_sel;
    logic [5:0]  func_sel;
    logic [2:0]  ien;
    logic [2:0]  istat;
    logic [2:0]  istat_clr;
    logic [31:0] rdata_nxt;
    logic        err_nxt;

    assign req_ready = (state == ST_IDLE) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = ST_RESP;
        else if (state == ST_RESP && rsp_ready)
            state_nxt = ST_IDLE;
    end

`ifdef GPIO_CTRL_REGS_LOCK_EN
    logic lock;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lock <= 1'b0;
        else if (accept && req_we && req_addr == ADDR_LOCK && req_wdata == {24'b0, LOCK_KEY})
            lock <= 1'b1;
    end

    assign wr_blocked = req_we && lock && (req_addr == ADDR_DIR || req_addr == ADDR_FUNC);
`else
    assign wr_blocked = 1'b0;
`endif

    always_comb begin
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        case (req_addr)
            ADDR_DATA:  rdata_nxt = {16'b0, data_in};
            ADDR_DIR:   rdata_nxt = {16'b0, dir_in};
            ADDR_PIN:   rdata_nxt = {16'b0, gpio_data_in};
            ADDR_IMASK: rdata_nxt = interrupt_mask;
            ADDR_PCMSK: rdata_nxt = {16'b0, pinchange_msk};
            ADDR_EDGE:  rdata_nxt = {28'b0, edge_sel};
            ADDR_FUNC:  rdata_nxt = {26'b0, func_sel};
            ADDR_ISTAT: rdata_nxt = {29'b0, istat};
            ADDR_IEN:   rdata_nxt = {29'b0, ien};
`ifdef GPIO_CTRL_REGS_LOCK_EN
            ADDR_LOCK:  rdata_nxt = {31'b0, lock};
`endif
            default:    err_nxt = 1'b1;
        endcase
        // Writes return zero data; only the error flag is meaningful.
        if (req_we)
            rdata_nxt = '0;
        if (wr_blocked)
            err_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata         <= '0;
            rsp_err           <= 1'b0;
            data_in           <= '0;
            dir_in            <= '0;
            write_data_enable <= 1'b0;
            write_dir_enable  <= 1'b0;
            interrupt_mask    <= '0;
            pinchange_msk     <= '0;
            edge_sel          <= '0;
            func_sel          <= '0;
            ien               <= '0;
        end else begin
            write_data_enable <= 1'b0;
            write_dir_enable  <= 1'b0;
            if (accept) begin
                rsp_rdata <= rdata_nxt;
                rsp_err   <= err_nxt;
                if (req_we && !wr_blocked) begin
                    case (req_addr)
                        ADDR_DATA: begin
                            data_in           <= req_wdata[15:0];
                            write_data_enable <= 1'b1;
                        end
                        ADDR_DIR: begin
                            dir_in           <= req_wdata[15:0];
                            write_dir_enable <= 1'b1;
                        end
                        ADDR_IMASK: interrupt_mask <= req_wdata;
                        ADDR_PCMSK: pinchange_msk  <= req_wdata[15:0];
                        ADDR_EDGE:  edge_sel       <= req_wdata[3:0];
                        ADDR_FUNC:  func_sel       <= req_wdata[5:0];
                        ADDR_IEN:   ien            <= req_wdata[2:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign istat_clr = (accept && req_we && req_addr == ADDR_ISTAT) ? req_wdata[2:0] : 3'b000;

    gpio_irq_capture u_irq_capture (
        .clk           (clk),
        .reset         (reset),
        .irq_int0      (irq_int0),
        .irq_int1      (irq_int1),
        .irq_pinchange (irq_pinchange),
        .clr           (istat_clr),
        .status        (istat)
    );

    assign int0_msk = edge_sel[1:0];
    assign int1_msk = edge_sel[3:2];
    assign {EN_UART, EN_SPI, EN_I2C, EN_TMR_IN0, EN_PWM_OUTB0, EN_PWM_OUTA0} = func_sel;
    assign irq = |(istat & ien);

endmodule

// File: tb/tb_gpio_ctrl_regs.sv
// Bench for gpio_ctrl_regs: directed scenarios followed by random register
// traffic, all checked against a register-map model held in the bench.
`timescale 1ns/1ps
module tb_gpio_ctrl_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] data_in, dir_in;
    logic        write_data_enable, write_dir_enable;
    logic [31:0] interrupt_mask;
    logic [15:0] pinchange_msk;
    logic [1:0]  int0_msk, int1_msk;
    logic        EN_PWM_OUTA0, EN_PWM_OUTB0, EN_TMR_IN0, EN_I2C, EN_SPI, EN_UART;
    logic [15:0] gpio_data_in = '0;
    logic        irq_int0 = 1'b0, irq_int1 = 1'b0, irq_pinchange = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    gpio_ctrl_regs dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .data_in(data_in), .dir_in(dir_in),
        .write_data_enable(write_data_enable), .write_dir_enable(write_dir_enable),
        .interrupt_mask(interrupt_mask), .pinchange_msk(pinchange_msk),
        .int0_msk(int0_msk), .int1_msk(int1_msk),
        .EN_PWM_OUTA0(EN_PWM_OUTA0), .EN_PWM_OUTB0(EN_PWM_OUTB0),
        .EN_TMR_IN0(EN_TMR_IN0), .EN_I2C(EN_I2C), .EN_SPI(EN_SPI), .EN_UART(EN_UART),
        .gpio_data_in(gpio_data_in),
        .irq_int0(irq_int0), .irq_int1(irq_int1), .irq_pinchange(irq_pinchange),
        .irq(irq)
    );

`ifdef GPIO_CTRL_REGS_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Register-map model
    logic [15:0] m_data, m_dir, m_pcmsk;
    logic [31:0] m_imask;
    logic [3:0]  m_edge;
    logic [5:0]  m_func;
    logic [2:0]  m_istat, m_ien, m_irq;
    logic        m_lock;

    logic [31:0] last_rd;
    logic        last_err, last_wde, last_wdir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_dir = '0; m_pcmsk = '0; m_imask = '0; m_edge = '0;
        m_func = '0; m_istat = '0; m_ien = '0; m_irq = '0; m_lock = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic [15:0] pins);
        case (a)
            4'd0: return {16'b0, m_data};
            4'd1: return {16'b0, m_dir};
            4'd2: return {16'b0, pins};
            4'd3: return m_imask;
            4'd4: return {16'b0, m_pcmsk};
            4'd5: return {28'b0, m_edge};
            4'd6: return {26'b0, m_func};
            4'd7: return {29'b0, m_istat};
            4'd8: return {29'b0, m_ien};
            4'd9: return LOCK_BUILD ? {31'b0, m_lock} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".data_in"}, {16'b0, data_in}, {16'b0, m_data});
        check({tag, ".dir_in"}, {16'b0, dir_in}, {16'b0, m_dir});
        check({tag, ".imask"}, interrupt_mask, m_imask);
        check({tag, ".pcmsk"}, {16'b0, pinchange_msk}, {16'b0, m_pcmsk});
        check({tag, ".edge"}, {28'b0, int1_msk, int0_msk}, {28'b0, m_edge});
        check({tag, ".func"}, {26'b0, EN_UART, EN_SPI, EN_I2C, EN_TMR_IN0, EN_PWM_OUTB0, EN_PWM_OUTA0},
              {26'b0, m_func});
        check({tag, ".irq"}, {31'b0, irq}, {31'b0, |(m_istat & m_ien)});
    endtask

    // One request with rsp_ready held high; irq levels and pins change with the request.
    task automatic xact(input string tag, input logic we, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [2:0] irqv, input logic [15:0] pins);
        logic [31:0] exp_rd;
        logic        blocked, exp_err;
        logic [2:0]  clr;
        @(negedge clk);
        check({tag, ".idle_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, ".idle_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, ".strobes_low"}, {30'b0, write_dir_enable, write_data_enable}, 32'd0);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b1;
        {irq_pinchange, irq_int1, irq_int0} = irqv;
        gpio_data_in = pins;

        blocked = we && m_lock && (addr == 4'd1 || addr == 4'd6);
        exp_err = (addr > 4'd8 && !(LOCK_BUILD && addr == 4'd9)) || blocked;
        exp_rd  = m_read(addr, pins);
        clr     = (we && addr == 4'd7) ? wd[2:0] : 3'b000;
        m_istat = (m_istat & ~clr) | (irqv & ~m_irq);
        m_irq   = irqv;
        if (we && !blocked) begin
            case (addr)
                4'd0: m_data  = wd[15:0];
                4'd1: m_dir   = wd[15:0];
                4'd3: m_imask = wd;
                4'd4: m_pcmsk = wd[15:0];
                4'd5: m_edge  = wd[3:0];
                4'd6: m_func  = wd[5:0];
                4'd8: m_ien   = wd[2:0];
                4'd9: if (LOCK_BUILD && wd == 32'h0000_00A5) m_lock = 1'b1;
                default: ;
            endcase
        end

        @(negedge clk);
        req_valid = 1'b0;
        last_rd = rsp_rdata; last_err = rsp_err;
        last_wde = write_data_enable; last_wdir = write_dir_enable;
        check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, ".rsp_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        if (!we)
            check({tag, ".rdata"}, rsp_rdata, exp_err ? 32'd0 : exp_rd);
        check({tag, ".wde"}, {31'b0, write_data_enable}, {31'b0, we && addr == 4'd0});
        check({tag, ".wdir"}, {31'b0, write_dir_enable}, {31'b0, we && addr == 4'd1 && !blocked});
        check({tag, ".b2b_ready"}, {31'b0, req_ready}, 32'd1);
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst.req_ready", {31'b0, req_ready}, 32'd1);
        check("rst.strobes", {30'b0, write_dir_enable, write_data_enable}, 32'd0);
        check("rst.rdata", rsp_rdata, 32'd0);
        check_outputs("rst");
        reset = 1'b1;

        // DATA write and one-cycle strobe
        xact("data_wr", 1'b1, 4'd0, 32'h0000_00F0, 3'b000, 16'h0000);
        check("data_wr.value", {16'b0, data_in}, 32'h0000_00F0);
        check("data_wr.strobe", {31'b0, last_wde}, 32'd1);
        @(negedge clk);
        check("data_wr.strobe_drop", {31'b0, write_data_enable}, 32'd0);

        // ISTAT set, clear and set-wins-over-clear
        xact("ien_wr", 1'b1, 4'd8, 32'h0000_0004, 3'b000, 16'h0000);
        xact("pc_rise", 1'b0, 4'd7, 32'd0, 3'b100, 16'h0000);
        xact("istat_rd", 1'b0, 4'd7, 32'd0, 3'b100, 16'h0000);
        check("istat_set", last_rd, 32'd4);
        check("irq_high", {31'b0, irq}, 32'd1);
        xact("istat_clr", 1'b1, 4'd7, 32'h0000_0004, 3'b100, 16'h0000);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        xact("pc_fall", 1'b0, 4'd7, 32'd0, 3'b000, 16'h0000);
        xact("set_vs_clr", 1'b1, 4'd7, 32'h0000_0004, 3'b100, 16'h0000);
        xact("set_wins_rd", 1'b0, 4'd7, 32'd0, 3'b100, 16'h0000);
        check("set_wins", last_rd, 32'd4);

        // Response held by rsp_ready=0
        xact("func_wr", 1'b1, 4'd6, 32'hFFFF_FFFF, 3'b100, 16'h0000);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd6; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("hold.rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold.rdata", rsp_rdata, 32'h0000_003F);
            check("hold.req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hold.release", {31'b0, rsp_valid}, 32'd0);

        // Unmapped address
        xact("unmapped", 1'b0, 4'hC, 32'd0, 3'b000, 16'hBEEF);
        check("unmapped.err", {31'b0, last_err}, 32'd1);
        check("unmapped.rdata", last_rd, 32'd0);

        // Reset in the middle of a pending write response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd0; req_wdata = 32'h1234; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst.pre_valid", {31'b0, rsp_valid}, 32'd1);
        #2 reset = 1'b0;
        {irq_pinchange, irq_int1, irq_int0} = 3'b000;
        model_reset();
        #1;
        check("midrst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst.req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst.strobes", {30'b0, write_dir_enable, write_data_enable}, 32'd0);
        check("midrst.rdata", {31'b0, rsp_err} | rsp_rdata, 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rsp_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst.after", {31'b0, rsp_valid}, 32'd0);

        // Random register traffic
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            a = (($urandom_range(0, 7)) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            xact("rand", 1'($urandom_range(0, 1)), a, $urandom,
                 3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
        end

`ifdef GPIO_CTRL_REGS_LOCK_EN
        xact("lk_dir0", 1'b1, 4'd1, 32'h0000_00FF, 3'b000, 16'h0000);
        xact("lk_set", 1'b1, 4'd9, 32'h0000_00A5, 3'b000, 16'h0000);
        xact("lk_rd", 1'b0, 4'd9, 32'd0, 3'b000, 16'h0000);
        check("lock.read", last_rd, 32'd1);
        xact("lk_dir", 1'b1, 4'd1, 32'h0000_FFFF, 3'b000, 16'h0000);
        check("lock.err", {31'b0, last_err}, 32'd1);
        check("lock.dir_kept", {16'b0, dir_in}, 32'h0000_00FF);
        check("lock.no_strobe", {31'b0, last_wdir}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpio_ctrl_regs.md
GPIO_CTRL_REGS -- requirements
Module: gpio_ctrl_regs

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports SHALL be synchronous to clk.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid/req_ready  in/out  1/1  request handshake.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  4  word address.
- req_wdata  in  32  write data.
- rsp_valid/rsp_ready  out/in  1/1  response handshake.
- rsp_rdata  out  32  read data.
- rsp_err  out  1  unmapped or blocked access.
- data_in, dir_in  out  16 each  to gpio_interface.
- write_data_enable, write_dir_enable  out  1 each  write strobes.
- interrupt_mask  out  32  interrupt mask.
- pinchange_msk  out  16  pin-change mask.
- int0_msk, int1_msk  out  2 each  edge selects.
- EN_PWM_OUTA0, EN_PWM_OUTB0, EN_TMR_IN0, EN_I2C, EN_SPI, EN_UART  out  1 each  alternate-function enables.
- gpio_data_in  in  16  pin state.
- irq_int0, irq_int1, irq_pinchange  in  1 each  interrupt levels.
- irq  out  1  combined interrupt.

Function
REQ-003 The register map SHALL be as follows; reads return the stored value zero-extended to 32 bits:
- 0 DATA RW [15:0]
- 1 DIR RW [15:0]
- 2 PIN RO [15:0]
- 3 IMASK RW [31:0]
- 4 PCMSK RW [15:0]
- 5 EDGE RW: [1:0] int0_msk, [3:2] int1_msk
- 6 FUNC RW: [5:0] = {EN_UART, EN_SPI, EN_I2C, EN_TMR_IN0, EN_PWM_OUTB0, EN_PWM_OUTA0}
- 7 ISTAT W1C [2:0]: {pinchange, int1, int0}
- 8 IEN RW [2:0]
REQ-004 The control FSM SHALL have states IDLE and RESP: IDLE→RESP on req_valid; RESP→IDLE on rsp_ready.
REQ-005 req_ready SHALL be high in IDLE, and in RESP when rsp_ready is high (back-to-back requests allowed).
REQ-006 A request SHALL be accepted on a cycle where req_valid and req_ready are both high.
REQ-007 rsp_valid SHALL rise on the cycle after acceptance (latency 1) and hold, with rsp_rdata and rsp_err stable, until rsp_ready is high.
REQ-008 A write SHALL update its register on the accept edge; register outputs SHALL therefore change in the same cycle rsp_valid rises.
REQ-009 A write to DATA (resp. DIR) SHALL assert write_data_enable (resp. write_dir_enable) for exactly one cycle, coincident with the new data_in (resp. dir_in) value.
REQ-010 A PIN read SHALL return gpio_data_in sampled on the accept edge; a PIN write SHALL have no effect and SHALL return rsp_err=0.
REQ-011 Access to addresses 9–15 SHALL return rsp_err=1 and rdata=0 with no state change, except as specified in REQ-019/REQ-020.
REQ-012 ISTAT bit n SHALL set on a 0→1 transition of its irq input, detected against a registered previous level.
REQ-013 Writing 1 to an ISTAT bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-014 If a set event and a W1C clear hit the same ISTAT bit in the same cycle, set SHALL win.
REQ-015 irq SHALL equal |(ISTAT & IEN), driven combinationally from registers.
REQ-016 Write data bits beyond a register's width SHALL be ignored.

Reset
REQ-017 While reset is low, every register, edge-history flop and output SHALL be 0: rsp_valid=0, req_ready=1 and both write strobes 0; the FSM SHALL be in IDLE.
REQ-018 Reset asserted mid-transaction SHALL abort it; the pending response SHALL be dropped and no strobe SHALL be emitted.

Configuration
REQ-019 With GPIO_CTRL_REGS_LOCK_EN defined, address 9 SHALL be LOCK:
- Writing 0xA5 sets a lock bit that only reset clears.
- While locked, writes to DIR and FUNC return rsp_err=1 with no update or strobe.
- A LOCK read returns {31'b0, lock}.
REQ-020 Without GPIO_CTRL_REGS_LOCK_EN, address 9 SHALL be unmapped per REQ-011 and no lock logic SHALL exist.

Structure
REQ-021 Package gpio_ctrl_pkg SHALL hold the address constants, the ISTAT bit indices, the FSM state type and the LOCK key value 0xA5.
REQ-022 Sub-module gpio_irq_capture SHALL implement edge detection and W1C sticky status for the three IRQ inputs.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus → required response):
- Write DATA=0x00F0 → next cycle: data_in=0x00F0, write_data_enable high exactly 1 cycle, rsp_valid=1, rsp_err=0.
- Pulse irq_pinchange 0→1 with IEN=0x4 → ISTAT=0x4 and irq=1; write ISTAT=0x4 → irq=0; write ISTAT=0x4 in the same cycle as a new rising edge → ISTAT stays 0x4.
- Hold rsp_ready=0 for 3 cycles after a read of FUNC=0x3F → rsp_rdata=0x3F stable throughout and req_ready=0.
- Read address 0xC → rsp_err=1, rdata=0.
- Assert reset low mid-response → rsp_valid=0, all outputs 0 immediately.
- With GPIO_CTRL_REGS_LOCK_EN: write LOCK=0xA5, then DIR=0xFFFF → rsp_err=1, dir_in unchanged, no write_dir_enable.
